// File: rtl/sched_flujo_pkg.sv
// sched_flujo_pkg: state encoding, phase codes and stage masks shared
// by the phase sequencer. Stage bit order: {d2, d1, e, v, i}.
package sched_flujo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_P0    = 3'd1,
        ST_P1    = 3'd2,
        ST_P2    = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;

    localparam logic [4:0] MASK_P0 = 5'b00011;
    localparam logic [4:0] MASK_P1 = 5'b00100;
    localparam logic [4:0] MASK_P2 = 5'b11000;

    // Stages owned by a state; empty outside the three phases.
    function automatic logic [4:0] phase_mask(state_t s);
        case (s)
            ST_P0:   return MASK_P0;
            ST_P1:   return MASK_P1;
            ST_P2:   return MASK_P2;
            default: return 5'b00000;
        endcase
    endfunction

    // Successor state once a phase has completed.
    function automatic state_t phase_next(state_t s);
        case (s)
            ST_P0:   return ST_P1;
            ST_P1:   return ST_P2;
            default: return ST_DONE;
        endcase
    endfunction

    function automatic logic [1:0] phase_code(state_t s);
        case (s)
            ST_P1:   return PH_1;
            ST_P2:   return PH_2;
            default: return PH_0;
        endcase
    endfunction

endpackage

// File: rtl/flujo_stage_hs.sv
// flujo_stage_hs: start/ack_seen register pair for one stage.
// Ports: clk; set (phase entry), clr (abort/error/reset), ack (already
// gated by phase-active); start and seen registered outputs.
module flujo_stage_hs (
    input  logic clk,
    input  logic set,
    input  logic clr,
    input  logic ack,
    output logic start,
    output logic seen
);

    always_ff @(posedge clk) begin
        if (clr) begin
            start <= 1'b0;
            seen  <= 1'b0;
        end else if (set) begin
            start <= 1'b1;
            seen  <= 1'b0;
        end else if (ack) begin
            start <= 1'b0;
            seen  <= 1'b1;
        end
    end

endmodule

// File: rtl/sched_flujo_datos.sv
// sched_flujo_datos: three-phase start/ack sequencer ({i,v} -> {e} ->
// {d1,d2}) with abort, completed-run counter and optional watchdog.
// Ports: clk, reset (sync, active-low), go, abort, ack_* in; start_*,
// busy, done, err, err_phase, cur_phase, runs_done out.
// Watchdog enabled by defining SCHED_FLUJO_WATCHDOG_EN.
module sched_flujo_datos #(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 5,
    parameter int RUN_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic             ack_i,
    input  logic             ack_v,
    input  logic             ack_e,
    input  logic             ack_d1,
    input  logic             ack_d2,
    output logic             start_i,
    output logic             start_v,
    output logic             start_e,
    output logic             start_d1,
    output logic             start_d2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_phase,
    output logic [1:0]       cur_phase,
    output logic [RUN_W-1:0] runs_done
);
    import sched_flujo_pkg::*;

    state_t     state, state_nxt;
    logic [4:0] acks, starts, seens, sets, act;
    logic       clr_all, err_load, cmp, tmo, clr;

    assign acks = {ack_d2, ack_d1, ack_e, ack_v, ack_i};
    assign {start_d2, start_d1, start_e, start_v, start_i} = starts;

    assign act       = phase_mask(state);
    assign busy      = (act != 5'b00000);
    assign done      = (state == ST_DONE);
    assign cur_phase = busy ? phase_code(state) : PH_0;

    // A stage counts as complete if seen earlier or acking right now.
    assign cmp = busy && (((seens | acks) & act) == act);
    assign clr = !reset || clr_all;

    for (genvar g = 0; g < 5; g++) begin : g_hs
        flujo_stage_hs u_hs (
            .clk   (clk),
            .set   (sets[g]),
            .clr   (clr),
            .ack   (acks[g] & act[g]),
            .start (starts[g]),
            .seen  (seens[g])
        );
    end

    always_comb begin
        state_nxt = state;
        sets      = 5'b00000;
        clr_all   = 1'b0;
        err_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nxt = ST_P0;
                    sets      = MASK_P0;
                end
            end
            ST_P0, ST_P1, ST_P2: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    clr_all   = 1'b1;
                end else if (cmp) begin
                    state_nxt = phase_next(state);
                    sets      = phase_mask(phase_next(state));
                end else if (tmo) begin
                    state_nxt = ST_ERROR;
                    clr_all   = 1'b1;
                    err_load  = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERROR: if (go) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            runs_done <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_DONE)
                runs_done <= runs_done + RUN_W'(1);
        end
    end

`ifdef SCHED_FLUJO_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd;
    logic [1:0]           err_ph;

    // Counter value TIMEOUT-2 means this is the phase's TIMEOUT-1'th
    // stalled cycle; the edge closing it lands in ERROR.
    assign tmo       = busy && (wd == TIMEOUT_W'(TIMEOUT - 2));
    assign err       = (state == ST_ERROR);
    assign err_phase = err_ph;

    always_ff @(posedge clk) begin
        if (!reset || (sets != 5'b00000))
            wd <= '0;
        else if (busy && !cmp)
            wd <= wd + TIMEOUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            err_ph <= PH_0;
        else if (err_load)
            err_ph <= phase_code(state);
    end
`else
    logic unused_cfg;

    assign tmo        = 1'b0;
    assign err        = 1'b0;
    assign err_phase  = 2'd0;
    assign unused_cfg = ^{err_load, TIMEOUT[0], TIMEOUT_W[0]};
`endif

endmodule

// File: tb/tb_sched_flujo_datos.sv
// tb_sched_flujo_datos: directed stimulus for the phase sequencer,
// checked each cycle against a pending-mask model plus literal checks.
module tb_sched_flujo_datos;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset, go, abort;
    logic [4:0] ack;
    logic       start_i, start_v, start_e, start_d1, start_d2;
    logic       busy, done, err;
    logic [1:0] err_phase, cur_phase;
    logic [7:0] runs_done;

    int vectors     = 0;
    int miscompares = 0;
    bit chk         = 1'b0;

    always #5 clk = ~clk;

    sched_flujo_datos #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (5),
        .RUN_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .abort     (abort),
        .ack_i     (ack[0]),
        .ack_v     (ack[1]),
        .ack_e     (ack[2]),
        .ack_d1    (ack[3]),
        .ack_d2    (ack[4]),
        .start_i   (start_i),
        .start_v   (start_v),
        .start_e   (start_e),
        .start_d1  (start_d1),
        .start_d2  (start_d2),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_phase (err_phase),
        .cur_phase (cur_phase),
        .runs_done (runs_done)
    );

    // Model: mode 0 idle, 1 running, 2 done, 3 error.
    // m_pend holds the stages of the current phase not yet acked.
    int         m_mode, m_ph, m_wait, m_runs, m_errph;
    logic [4:0] m_pend;

    function automatic logic [4:0] stages(int ph);
        case (ph)
            0:       return 5'b00011;
            1:       return 5'b00100;
            default: return 5'b11000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0; m_ph = 0; m_pend = 0;
            m_wait = 0; m_runs = 0; m_errph = 0;
        end else begin
            case (m_mode)
                0: if (go) begin
                    m_mode = 1; m_ph = 0;
                    m_pend = stages(0); m_wait = 0;
                end
                1: if (abort) begin
                    m_mode = 0; m_pend = 0;
                end else if ((m_pend & ~ack) == 5'b0) begin
                    if (m_ph == 2) begin
                        m_mode = 2; m_pend = 0; m_runs++;
                    end else begin
                        m_ph++; m_pend = stages(m_ph); m_wait = 0;
                    end
                end else begin
                    m_pend = m_pend & ~ack;
                    m_wait++;
`ifdef SCHED_FLUJO_WATCHDOG_EN
                    if (m_wait == TIMEOUT - 1) begin
                        m_mode = 3; m_errph = m_ph; m_pend = 0;
                    end
`endif
                end
                2: m_mode = 0;
                default: if (go) m_mode = 0;
            endcase
        end
    end

    logic [20:0] got_v, want_v;

    always @(negedge clk) begin
        if (chk) begin
            got_v = {start_d2, start_d1, start_e, start_v, start_i,
                     busy, done, err, err_phase, cur_phase, runs_done};
            want_v = {m_pend, m_mode == 1, m_mode == 2, m_mode == 3,
`ifdef SCHED_FLUJO_WATCHDOG_EN
                      2'(m_errph),
`else
                      2'd0,
`endif
                      (m_mode == 1) ? 2'(m_ph) : 2'd0, 8'(m_runs)};
            vectors++;
            if (got_v !== want_v) begin
                miscompares++;
                $display("FAIL cycle t=%0t got %h want %h",
                         $time, got_v, want_v);
            end
        end
    end

    task automatic lit(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] a);
        ack = a;
        cyc(1);
        ack = 5'b0;
    endtask

    task automatic start_run();
        go = 1'b1;
        cyc(1);
        go = 1'b0;
    endtask

    task automatic fast_run();
        start_run();
        pulse(5'b00011);
        pulse(5'b00100);
        pulse(5'b11000);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; abort = 1'b0; ack = 5'b0;
        cyc(1);
        chk = 1'b1;
        cyc(2);
        reset = 1'b1;
        lit("rst_busy", busy, 0);
        lit("rst_runs", runs_done, 0);

        // go sampled at cycle 5, ack_i at 7, ack_v at 9
        cyc(1);
        start_run();
        lit("p0_starts", {start_v, start_i}, 3);
        cyc(1);
        pulse(5'b00001);
        lit("ack_i_drop", {start_v, start_i}, 2);
        lit("still_p0", cur_phase, 0);
        cyc(1);
        pulse(5'b00010);
        lit("p1_start_e", start_e, 1);
        lit("p1_phase", cur_phase, 1);
        cyc(1);
        pulse(5'b00100);
        pulse(5'b11000);
        lit("done_1", done, 1);
        lit("runs_1", runs_done, 1);
        cyc(1);
        lit("done_pulse", done, 0);
        lit("idle_busy", busy, 0);

        // acks two cycles after each start
        start_run();
        for (int p = 0; p < 3; p++) begin
            cyc(1);
            pulse(stages(p));
        end
        lit("done_2", done, 1);
        lit("runs_2", runs_done, 2);
        cyc(1);
        lit("after_done", {busy, done}, 0);

        // early acks for later stages are ignored
        start_run();
        pulse(5'b01100);
        lit("early_e", start_e, 0);
        pulse(5'b00011);
        cyc(2);
        lit("p1_waits", start_e, 1);
        lit("p1_waits_ph", cur_phase, 1);
        pulse(5'b00100);
        lit("p2_starts", {start_d2, start_d1}, 3);
        pulse(5'b11000);
        cyc(1);
        lit("runs_3", runs_done, 3);

        // abort in P2 after only ack_d1
        start_run();
        pulse(5'b00011);
        pulse(5'b00100);
        pulse(5'b01000);
        lit("d1_only", {start_d2, start_d1}, 2);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        lit("abort_busy", busy, 0);
        lit("abort_starts", start_d2, 0);
        lit("abort_runs", runs_done, 3);
        cyc(3);
        lit("abort_nodone", done, 0);

        // stall in P1
        start_run();
        pulse(5'b00011);
`ifdef SCHED_FLUJO_WATCHDOG_EN
        cyc(14);
        lit("wd_pre", err, 0);
        cyc(1);
        lit("wd_err", err, 1);
        lit("wd_phase", err_phase, 1);
        lit("wd_start_e", start_e, 0);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        lit("wd_clear", err, 0);
        lit("wd_hold_ph", err_phase, 1);
`else
        cyc(40);
        lit("no_wd_err", err, 0);
        lit("no_wd_wait", start_e, 1);
        pulse(5'b00100);
        pulse(5'b11000);
        cyc(1);
        lit("runs_4", runs_done, 4);
`endif

        // back-to-back runs up to the wrap point
        begin
            int n;
            n = 256 - (m_runs % 256);
            repeat (n) fast_run();
        end
        lit("runs_wrap", runs_done, 0);

        // reset mid-P1
        start_run();
        pulse(5'b00011);
        lit("pre_rst_p1", cur_phase, 1);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        lit("mid_rst_out",
            {start_d2, start_d1, start_e, start_v, start_i,
             busy, done, err, cur_phase}, 0);
        lit("mid_rst_runs", runs_done, 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sched_flujo_datos.md
Name: sched_flujo_datos

Overview:
- Phase sequencer for the five-stage datapath: input (i), validation (v), execution (e), and two output drivers (d1, d2).
- Issues start/ack handshakes in three ordered phases: P0 = {i,v} in parallel, P1 = {e}, P2 = {d1,d2} in parallel.
- Adds per-phase completion tracking, abort, a completed-run counter and an optional watchdog.
- Sits between the top-level command logic (go/abort) and the stage units.

Parameters:
- TIMEOUT, 16, watchdog limit in cycles per phase (watchdog build only).
- TIMEOUT_W, 5, width of the watchdog counter; must satisfy 2^TIMEOUT_W > TIMEOUT.
- RUN_W, 8, width of the completed-run counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- go  in  1  start a sequence (IDLE), or clear an error (ERROR).
- abort  in  1  synchronous abort of the current sequence.
- ack_i, ack_v, ack_e, ack_d1, ack_d2  in  1 each  stage-complete acks; pulse or level.
- start_i, start_v, start_e, start_d1, start_d2  out  1 each  stage start requests, registered.
- busy  out  1  high in P0/P1/P2.
- done  out  1  one-cycle pulse on sequence completion.
- err  out  1  watchdog error, sticky.
- err_phase  out  2  phase that timed out (0..2).
- cur_phase  out  2  current phase; 0 when not busy.
- runs_done  out  RUN_W  completed sequences; wraps modulo 2^RUN_W.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all starts, busy, done and err = 0; err_phase, cur_phase and runs_done = 0; ack-seen flags and watchdog counter cleared. Reset mid-sequence behaves identically.
- States: IDLE, P0, P1, P2, DONE, ERROR.
- IDLE:
  - go=1 at edge k -> P0 after edge k.
  - start_i and start_v are high in cycle k+1 (latency 1).
- Phase entry: clears that phase's ack_seen flags and the watchdog counter, and sets the start of every stage in the phase.
- Per stage in the active phase:
  - ack sampled high at an edge -> ack_seen set and the stage's start cleared at that edge.
  - start stays high until then.
- Phase completion: at the edge where every stage in the phase is seen or has its ack high in that cycle, advance P0->P1->P2->DONE. The next phase's starts are asserted from that edge.
  - Example: simultaneous ack_i and ack_v in the first cycle of P0 -> P1 with start_e=1 on the next cycle.
- Acks for stages outside the active phase are ignored, including early acks.
- DONE: lasts one cycle with done=1; runs_done increments; busy=0; then IDLE. go is ignored in DONE.
- abort:
  - In P0/P1/P2: -> IDLE at the next edge; all starts 0; no done; runs_done unchanged.
  - Ignored in IDLE, DONE and ERROR.
- Priority: reset > abort > phase completion > watchdog timeout.
- cur_phase = 0/1/2 in P0/P1/P2, else 0.

Optional Feature:
- Macro: SCHED_FLUJO_WATCHDOG_EN.
- When defined:
  - The counter increments every cycle a phase is active without completing.
  - On reaching TIMEOUT-1 -> ERROR; all starts 0; err=1; err_phase = that phase.
  - Completion in the same cycle as the timeout wins.
  - In ERROR, go=1 -> IDLE with err cleared; err_phase holds its value.
- When undefined: no counter logic; ERROR is unreachable; err and err_phase are tied to 0; phases wait indefinitely.

Decomposition:
- Package sched_flujo_pkg: state encoding localparams (IDLE, P0, P1, P2, DONE, ERROR) and phase codes.
- Sub-module flujo_stage_hs, instantiated five times: start/ack_seen register pair with inputs set (phase entry), clr (abort/error/reset) and ack; outputs start and seen.

Test Plan:
- Reset held 3 cycles, then go at cycle 5; ack_i at cycle 7, ack_v at cycle 9 -> start_i falls after 7, start_e rises after 9, cur_phase goes 0 -> 1.
- Full run with every ack arriving 2 cycles after its start -> done pulses exactly 1 cycle, runs_done=1, busy=0 the cycle after done.
- ack_e and ack_d1 pulsed during P0 -> ignored; P1 still waits for a fresh ack_e.
- abort asserted in P2 after ack_d1 only -> IDLE next edge, all starts 0, done never asserted, runs_done unchanged.
- Watchdog build, TIMEOUT=16, no ack_e -> ERROR after 15 cycles in P1, err=1, err_phase=1; go -> IDLE with err=0.
- 256 back-to-back runs with RUN_W=8 -> runs_done wraps to 0; reset asserted mid-P1 -> all outputs 0 on the next cycle.
